// File: rtl/bitstream_pkg.sv
// Shared types and helpers for the bitstream packer slice.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package bitstream_pkg;

    // Packer mode: normal packing or draining a flush.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pk_state_e;

    localparam int DEFAULT_MAX_CODE_BITS = 32;
    localparam int MAX_OUT_BYTES         = 64;

    // Width of a codeword-length field able to hold 0..max_code_bits.
    function automatic int size_width(input int max_code_bits);
        return $clog2(max_code_bits + 1);
    endfunction

    // Byte-enable mask for a partial word holding `fill` bits, MSB byte first.
    // The result is right-aligned in MAX_OUT_BYTES bits; callers truncate it to
    // their own OUT_BYTES.
    function automatic logic [MAX_OUT_BYTES-1:0] byte_en_from_fill(input int fill,
                                                                   input int out_bytes);
        logic [MAX_OUT_BYTES-1:0] m;
        int                       nbytes;
        m      = '0;
        nbytes = (fill + 7) / 8;
        for (int i = 0; i < MAX_OUT_BYTES; i++) begin
            if (i < out_bytes && i >= out_bytes - nbytes) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bitstream_packer_codeword_aligner.sv
// Masks a right-aligned codeword to its length and moves it to the accumulator insert slot.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is used.
module codeword_aligner
    import bitstream_pkg::*;
#(
    parameter int MAX_CODE_BITS = DEFAULT_MAX_CODE_BITS,
    parameter int ACC_BITS      = 64,
    parameter int SW            = 6,
    parameter int FW            = 7
) (
    input  logic [MAX_CODE_BITS-1:0] code_val,
    input  logic [SW-1:0]            code_size,
    input  logic [FW-1:0]            ins_fill,
    output logic [SW-1:0]            eff_size,
    output logic [ACC_BITS-1:0]      ins_bits
);

    logic [MAX_CODE_BITS-1:0] masked;
    int                       shift;

    // Saturate the length, drop bits above it, and place the code just below the fill point.
    always_comb begin
        eff_size = (code_size > SW'(MAX_CODE_BITS)) ? SW'(MAX_CODE_BITS) : code_size;
        masked   = '0;
        for (int i = 0; i < MAX_CODE_BITS; i++) begin
            masked[i] = code_val[i] & (i < int'(eff_size));
        end
        shift = ACC_BITS - int'(ins_fill) - int'(eff_size);
        if (shift < 0 || shift >= ACC_BITS) begin
            ins_bits = '0;
        end else begin
            ins_bits = {{(ACC_BITS-MAX_CODE_BITS){1'b0}}, masked} << shift;
        end
    end

endmodule

// File: rtl/bitstream_packer.sv
// Packs variable-length codewords MSB-first into OUT_BYTES-wide words; optional flush pads to a byte boundary.
// Latency: a codeword completing a word shows out_valid the next cycle; outputs come from registers only.
// Backpressure: in_ready drops while a full word waits or a flush drains; outputs hold while !out_ready. Optional BITSTREAM_PACKER_BIT_COUNT_EN adds total_bits.
module bitstream_packer
    import bitstream_pkg::*;
#(
    parameter int OUT_BYTES     = 4,
    parameter int MAX_CODE_BITS = DEFAULT_MAX_CODE_BITS
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [MAX_CODE_BITS-1:0]           in_val,
    input  logic [$clog2(MAX_CODE_BITS+1)-1:0] in_size,
    input  logic                               in_flush,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_BYTES*8-1:0]             out_data,
    output logic [OUT_BYTES-1:0]               out_byte_en,
    output logic                               out_last,
    output logic                               flush_done
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
    ,
    output logic [31:0]                        total_bits
`endif
);

    localparam int W  = OUT_BYTES * 8;
    localparam int A  = W + MAX_CODE_BITS;
    localparam int SW = size_width(MAX_CODE_BITS);
    localparam int FW = $clog2(A + 1);

    pk_state_e      st_q, st_d;
    logic [A-1:0]   acc_q, acc_d, acc_pop, ins_bits;
    logic [FW-1:0]  fill_q, fill_d, fill_pop;
    logic [SW-1:0]  eff_size;
    logic           flush_done_q, flush_done_d;
    logic           push, pop;
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
    logic [31:0]    total_bits_q, total_bits_d;
`endif

    // The aligner works against the post-pop fill so a same-cycle push and pop compose.
    codeword_aligner #(
        .MAX_CODE_BITS (MAX_CODE_BITS),
        .ACC_BITS      (A),
        .SW            (SW),
        .FW            (FW)
    ) u_aligner (
        .code_val  (in_val),
        .code_size (in_size),
        .ins_fill  (fill_pop),
        .eff_size  (eff_size),
        .ins_bits  (ins_bits)
    );

    // State register: accumulator, fill, mode and the flush-done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q         <= ST_RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            flush_done_q <= 1'b0;
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
            total_bits_q <= '0;
`endif
        end else begin
            st_q         <= st_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            flush_done_q <= flush_done_d;
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
            total_bits_q <= total_bits_d;
`endif
        end
    end

    // Next state: pop shift first, then insert the codeword, then flush sequencing.
    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        acc_pop  = pop ? (acc_q << W) : acc_q;
        fill_pop = pop ? (fill_q - FW'(W)) : fill_q;

        acc_d        = acc_pop;
        fill_d       = fill_pop;
        st_d         = st_q;
        flush_done_d = 1'b0;
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
        total_bits_d = total_bits_q;
`endif

        if (push) begin
            acc_d  = acc_pop | ins_bits;
            fill_d = fill_pop + FW'(eff_size);
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
            total_bits_d = total_bits_q + 32'(eff_size);
`endif
        end

        case (st_q)
            ST_RUN: begin
                // An empty flush has nothing to drain and completes immediately.
                if (push && in_flush) begin
                    if (fill_d == '0) begin
                        flush_done_d = 1'b1;
                    end else begin
                        st_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (pop && out_last) begin
                    st_d         = ST_RUN;
                    acc_d        = '0;
                    fill_d       = '0;
                    flush_done_d = 1'b1;
                end
            end
            default: st_d = ST_RUN;
        endcase
    end

    // Outputs decoded from registered state only; padding bits below fill are already zero.
    always_comb begin
        in_ready    = (st_q == ST_RUN) && (fill_q < FW'(W));
        out_valid   = (st_q == ST_RUN) ? (fill_q >= FW'(W)) : (fill_q != '0);
        out_last    = (st_q == ST_FLUSH) && (fill_q != '0) && (fill_q <= FW'(W));
        out_byte_en = '1;
        if (st_q == ST_FLUSH && fill_q < FW'(W)) begin
            out_byte_en = OUT_BYTES'(byte_en_from_fill(int'(fill_q), OUT_BYTES));
        end
        out_data    = acc_q[A-1 -: W];
        flush_done  = flush_done_q;
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
        total_bits  = total_bits_q;
`endif
    end

endmodule

// File: tb/tb_bitstream_packer.sv
// Directed bench for bitstream_packer with OUT_BYTES=4, MAX_CODE_BITS=32.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: out_ready is held low except for explicit single-cycle pops.
module tb_bitstream_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_val;
    logic [5:0]  in_size;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_byte_en;
    logic        out_last;
    logic        flush_done;
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
    logic [31:0] total_bits;
`endif

    int n_total  = 0;
    int n_passed = 0;

    always #5 clk = ~clk;

    bitstream_packer #(.OUT_BYTES(4), .MAX_CODE_BITS(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_val      (in_val),
        .in_size     (in_size),
        .in_flush    (in_flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_byte_en (out_byte_en),
        .out_last    (out_last),
        .flush_done  (flush_done)
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
        ,
        .total_bits  (total_bits)
`endif
    );

    typedef struct {
        logic [31:0] val;
        logic [5:0]  size;
        logic        flush;
        logic        exp_vld;
        logic [31:0] exp_dat;
        logic [3:0]  exp_be;
        logic        exp_last;
        logic        exp_done;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    task automatic push(input logic [31:0] v, input logic [5:0] s, input logic f);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL push_wait: in_ready stayed 0 for %0d cycles, expected 1", n);
        end
        in_valid = 1'b1;
        in_val   = v;
        in_size  = s;
        in_flush = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        //            val            size   fl    vld   data           be     last  done
        vecs[0]  = '{32'h000000A5, 6'd8,  1'b0, 1'b0, 32'h00000000, 4'hF, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000003C, 6'd8,  1'b0, 1'b0, 32'h00000000, 4'hF, 1'b0, 1'b0};
        vecs[2]  = '{32'h000000FF, 6'd8,  1'b0, 1'b0, 32'h00000000, 4'hF, 1'b0, 1'b0};
        vecs[3]  = '{32'h00000001, 6'd8,  1'b0, 1'b1, 32'hA53CFF01, 4'hF, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000005, 6'd3,  1'b1, 1'b1, 32'hA0000000, 4'h8, 1'b1, 1'b1};
        vecs[5]  = '{32'hFFFFFFFF, 6'd4,  1'b0, 1'b0, 32'h00000000, 4'hF, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 6'd0,  1'b0, 1'b0, 32'h00000000, 4'hF, 1'b0, 1'b0};
        vecs[7]  = '{32'h00000000, 6'd28, 1'b0, 1'b1, 32'hF0000000, 4'hF, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000123, 6'd0,  1'b1, 1'b0, 32'h00000000, 4'hF, 1'b0, 1'b1};
        vecs[9]  = '{32'h000001FF, 6'd9,  1'b0, 1'b0, 32'h00000000, 4'hF, 1'b0, 1'b0};
        vecs[10] = '{32'h007FFFFF, 6'd23, 1'b1, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1};
        vecs[11] = '{32'h12345678, 6'd40, 1'b0, 1'b1, 32'h12345678, 4'hF, 1'b0, 1'b0};
        vecs[12] = '{32'h00000ABC, 6'd12, 1'b1, 1'b1, 32'hABC00000, 4'hC, 1'b1, 1'b1};
        vecs[13] = '{32'h0001FFFF, 6'd17, 1'b1, 1'b1, 32'hFFFF8000, 4'hE, 1'b1, 1'b1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_val    = '0;
        in_size   = '0;
        in_flush  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_byte_en", out_byte_en, 4'hF);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
        check("rst_total_bits", total_bits, 32'd0);
`endif

        for (int i = 0; i < 14; i++) begin
            push(vecs[i].val, vecs[i].size, vecs[i].flush);
            check($sformatf("v%0d_valid", i), out_valid, vecs[i].exp_vld);
            if (vecs[i].exp_vld) begin
                check($sformatf("v%0d_data", i), out_data, vecs[i].exp_dat);
                check($sformatf("v%0d_be", i), out_byte_en, vecs[i].exp_be);
                check($sformatf("v%0d_last", i), out_last, vecs[i].exp_last);
                pop();
            end
            check($sformatf("v%0d_done", i), flush_done, vecs[i].exp_done);
            if (vecs[i].exp_done) begin
                check($sformatf("v%0d_ready_after_flush", i), in_ready, 1'b1);
            end
        end
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
        check("table_total_bits", total_bits, 32'd160);
`endif

        // Backpressure with 40 bits buffered: word held, no accepts, then drain resumes.
        push(32'h00AABBCC, 6'd24, 1'b0);
        push(32'h0000DDEE, 6'd16, 1'b0);
        check("bp_in_ready", in_ready, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_%0d", c), {out_valid, in_ready, out_data},
                  {1'b1, 1'b0, 32'hAABBCCDD});
        end
        pop();
        check("bp_after_pop_valid", out_valid, 1'b0);
        check("bp_after_pop_ready", in_ready, 1'b1);
        push(32'h00123456, 6'd24, 1'b0);
        check("bp_next_word", {out_valid, out_data}, {1'b1, 32'hEE123456});
        pop();

        // Flush draining two words: a full non-last word, then a padded last word.
        push(32'h00AABBCC, 6'd24, 1'b0);
        push(32'h0000DDEE, 6'd16, 1'b1);
        check("fl_w0", {out_valid, out_last, out_byte_en, out_data},
              {1'b1, 1'b0, 4'hF, 32'hAABBCCDD});
        check("fl_w0_in_ready", in_ready, 1'b0);
        pop();
        check("fl_w1", {out_valid, out_last, out_byte_en, out_data},
              {1'b1, 1'b1, 4'h8, 32'hEE000000});
        check("fl_w1_done", flush_done, 1'b0);
        pop();
        check("fl_done", {flush_done, in_ready, out_valid}, {1'b1, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        check("fl_done_pulse_end", flush_done, 1'b0);

        // Reset in the middle of a flush drain discards everything.
        push(32'h00AABBCC, 6'd24, 1'b0);
        push(32'h0000DDEE, 6'd16, 1'b1);
        check("rr_pre_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rr_cleared", {out_valid, out_last, flush_done}, {1'b0, 1'b0, 1'b0});
`ifdef BITSTREAM_PACKER_BIT_COUNT_EN
        check("rr_total_bits", total_bits, 32'd0);
`endif
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rr_after", {in_ready, out_valid, flush_done, out_byte_en},
              {1'b1, 1'b0, 1'b0, 4'hF});

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/bitstream_packer.md
# bitstream_packer

Parametrised successor to the encoder's single-width bit setter. It packs variable-length codewords from the DC, AC-run and AC-level entropy coders into fixed-width MSB-first output words, using valid/ready handshakes on both sides. It also supports an explicit flush that zero-pads to a byte boundary and emits a partial final word with byte enables. The block sits between the entropy coders and the slice/frame writer.

## Interface
Parameters:
- OUT_BYTES, default 4: output word width in bytes; W = OUT_BYTES*8.
- MAX_CODE_BITS, default 32: maximum codeword length; accumulator width A = W + MAX_CODE_BITS.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  codeword present.
- in_ready  out  1  packer can accept.
- in_val  in  MAX_CODE_BITS  codeword, right-aligned; bits at or above in_size are ignored (masked).
- in_size  in  $clog2(MAX_CODE_BITS+1)  codeword length 0..MAX_CODE_BITS; 0 is a legal no-op; values above MAX_CODE_BITS saturate to MAX_CODE_BITS.
- in_flush  in  1  qualified by in_valid; pad and drain after appending this codeword.
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts.
- out_data  out  W  packed bits; first bit is at the MSB.
- out_byte_en  out  OUT_BYTES  valid bytes, MSB byte first; all ones except on a partial flush word.
- out_last  out  1  final word of a flush.
- flush_done  out  1  one-cycle pulse when a flush completes.
- total_bits  out  32  present only with BITSTREAM_PACKER_BIT_COUNT_EN.

## Operation
- State: acc[A-1:0] (MSB-aligned bit store), fill (count of valid bits, 0..A-1), st ∈ {RUN, FLUSH}.
- Input accept = in_valid && in_ready.
- in_ready = (st==RUN) && (fill < W). This guarantees fill + size ≤ A-1.
- On accept, the masked codeword is written at bit positions A-1-fill down to A-fill-size.
- Output words:
  - In RUN, out_valid = (fill ≥ W).
  - out_data = acc[A-1 -: W].
  - On a pop (out_valid && out_ready), acc shifts left by W and fill decreases by W.
- Simultaneous push and pop: the pop shift is applied first, the codeword is placed at the post-pop fill, and fill_next = fill − W + size.
- Accept with in_flush=1 moves to FLUSH; in_ready is held 0 until the flush completes.
- In FLUSH:
  - fill ≥ W: emit a full word. out_last = 1 only if fill == W.
  - 0 < fill < W: emit one word with zero padding. out_byte_en has the top ceil(fill/8) bits set. out_last = 1.
  - After the out_last pop, or if fill == 0 on entry: pulse flush_done, fill=0, return to RUN.
- out_last and out_byte_en ≠ all-ones occur only in FLUSH.
- Reset values: acc=0, fill=0, st=RUN, out_valid=0, out_last=0, out_byte_en=all-ones, flush_done=0, total_bits=0; in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation (including mid-flush) discards all buffered bits. No out_last is produced.

## Timing
- All outputs are derived from registers only; there is no combinational path from in_* to out_*. in_ready depends only on registered state.
- Latency: a codeword accepted at edge N that completes a word gives out_valid=1 in cycle N+1.
- out_data, out_byte_en and out_last hold stable while out_valid && !out_ready.
- Sustained throughput: one word per cycle when the average input rate is ≥ W bits per cycle and is limited only by in_ready.
- flush_done asserts the cycle after the final pop, or the cycle after the flush accept when fill was 0.

## Configuration
- BITSTREAM_PACKER_BIT_COUNT_EN defined:
  - total_bits counts the in_size of accepted codewords, excluding padding.
  - It wraps mod 2^32 and is cleared only by reset.
- BITSTREAM_PACKER_BIT_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package bitstream_pkg contains:
  - the typedef enum for {RUN, FLUSH};
  - the function byte_en_from_fill(fill) returning the OUT_BYTES mask;
  - a localparam helper for the size width.
- Sub-module codeword_aligner: combinational; masks in_val to in_size and shifts it to the accumulator insertion offset. The packer top holds the state machine, accumulator and handshakes.

## Test plan
All cases use OUT_BYTES=4 and MAX_CODE_BITS=32.
1. After reset, four size-8 codes 0xA5, 0x3C, 0xFF, 0x01 with out_ready=1 -> one word 0xA53CFF01, byte_en 4'b1111, out_last=0, out_valid in the cycle after the 4th accept.
2. Code 0b101 size 3 with in_flush -> 0xA0000000, byte_en 4'b1000, out_last=1, flush_done one cycle after the pop, in_ready back to 1.
3. out_ready=0 with fill=40 -> in_ready=0 and out_data held stable for 10 cycles; on release the first word pops, and fill=8 allows the next accept.
4. in_val=0xFFFFFFFF, size 4, then size 28 of 0 -> word 0xF0000000 (upper bits masked). in_size=0 leaves fill unchanged.
5. Flush with fill=0 -> no out_valid, flush_done pulses the next cycle; flush with fill=32 -> a single word with out_last=1 and byte_en 4'b1111.
6. reset_n low during a FLUSH drain -> out_valid=0 and fill=0 next cycle, no flush_done; total_bits=0 when the macro is enabled.
